exp5_exibe_sequencia: RTL and testbench

Sequence-presentation unit for the memory game: on `iniciar`, reads the stored sequence from the 16x4 sequence memory, address 0 up to a round limit, and lights each entry on the LEDs for a fixed on-time followed by a dark gap. This is the output direction of the game loop: it shows the sequence that the play-checking control unit later compares against the player's moves. It drives the memory address in place of the play counter during presentation and raises `pronto` when the last entry has been shown.

---
 rtl/exp5_exibe_sequencia_pkg.sv | 21 ++
 rtl/exp5_temporizador.sv | 26 ++
 rtl/exp5_exibe_sequencia.sv | 111 +++++++++++
 tb/tb_exp5_exibe_sequencia.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/exp5_exibe_sequencia_pkg.sv
// Shared definitions for the memory-game sequence units: state codes, address
// width and memory depth, so db_estado decodes identically on the debug display.
package exp5_exibe_sequencia_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 4;
  localparam int unsigned MEM_DEPTH = 16;
  localparam int unsigned STATE_W   = 4;
  localparam int unsigned TIMER_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    st_inicial = 4'b0000,
    st_prepara = 4'b0001,
    st_carrega = 4'b0010,
    st_acende  = 4'b0011,
    st_apaga   = 4'b0100,
    st_proximo = 4'b0101,
    st_fim     = 4'b1000
  } estado_t;

endpackage

// File: rtl/exp5_temporizador.sv
// Up-counter with synchronous clear; fim_tempo flags that the count has
// reached the runtime limit.
module exp5_temporizador
  import exp5_exibe_sequencia_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               limpa,
  input  logic               conta,
  input  logic [TIMER_W-1:0] limite,
  output logic               fim_tempo
);

  logic [TIMER_W-1:0] contagem;

  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + TIMER_W'(1);
    end
  end

  assign fim_tempo = (contagem == limite);

endmodule

// File: rtl/exp5_exibe_sequencia.sv
// Presents the stored sequence on the LEDs, entry 0 up to the captured limit,
// each lit for ON_CYCLES then dark for OFF_CYCLES; pronto while finished.
module exp5_exibe_sequencia
  import exp5_exibe_sequencia_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [ADDR_W-1:0]  limite,
  input  logic [DATA_W-1:0]  dado_mem,
  output logic [ADDR_W-1:0]  endereco,
  output logic [DATA_W-1:0]  leds,
  output logic               exibindo,
  output logic               pronto,
  output logic [STATE_W-1:0] db_estado
);

  localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);

  estado_t             estado;
  estado_t             estado_prox;
  logic [ADDR_W-1:0]   lim_reg;
  logic [DATA_W-1:0]   led_reg;
  logic                limpa_tempo;
  logic                conta_tempo;
  logic                fim_tempo;
  logic [TIMER_W-1:0]  limite_tempo;
  logic                aceita;

  exp5_temporizador u_temporizador (
    .clock     (clock),
    .reset     (reset),
    .limpa     (limpa_tempo),
    .conta     (conta_tempo),
    .limite    (limite_tempo),
    .fim_tempo (fim_tempo)
  );

  // Next state and timer control; the timer only runs in acende/apaga.
  always_comb begin
    estado_prox  = st_inicial;
    limpa_tempo  = 1'b1;
    conta_tempo  = 1'b0;
    limite_tempo = ON_LAST;
    case (estado)
      st_inicial: estado_prox = iniciar ? st_prepara : st_inicial;
      st_prepara: estado_prox = st_carrega;
      st_carrega: estado_prox = st_acende;
      st_acende: begin
        conta_tempo = 1'b1;
        limpa_tempo = fim_tempo;
        estado_prox = fim_tempo ? st_apaga : st_acende;
      end
      st_apaga: begin
        limite_tempo = OFF_LAST;
        conta_tempo  = 1'b1;
        limpa_tempo  = fim_tempo;
        if (!fim_tempo) begin
          estado_prox = st_apaga;
        end else if (endereco == lim_reg) begin
          estado_prox = st_fim;
        end else begin
          estado_prox = st_proximo;
        end
      end
      st_proximo: estado_prox = st_carrega;
      st_fim:     estado_prox = iniciar ? st_prepara : st_fim;
      default:    estado_prox = st_inicial;
    endcase
  end

  assign aceita = ((estado == st_inicial) || (estado == st_fim)) && (estado_prox == st_prepara);

  // State, datapath registers and registered outputs derived from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= st_inicial;
      endereco  <= '0;
      lim_reg   <= '0;
      led_reg   <= '0;
      leds      <= '0;
      exibindo  <= 1'b0;
      pronto    <= 1'b0;
      db_estado <= '0;
    end else begin
      estado    <= estado_prox;
      db_estado <= STATE_W'(estado_prox);
      exibindo  <= (estado_prox != st_inicial) && (estado_prox != st_fim);
      pronto    <= (estado_prox == st_fim);
      if (aceita) begin
        endereco <= '0;
        lim_reg  <= limite;
      end else if (estado == st_proximo) begin
        endereco <= endereco + ADDR_W'(1);
      end
      if (estado == st_carrega) begin
        led_reg <= dado_mem;
      end
      if (estado_prox == st_acende) begin
        leds <= (estado == st_carrega) ? dado_mem : led_reg;
      end else begin
        leds <= '0;
      end
    end
  end

endmodule

// File: tb/tb_exp5_exibe_sequencia.sv
// Randomized bench for exp5_exibe_sequencia against a cycle-list reference
// built from the presentation rules (prepara, then carrega/lit/dark/proximo per entry).
module tb_exp5_exibe_sequencia;

  localparam int ON  = 3;
  localparam int OFF = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [3:0] db_estado;
  logic [3:0] mem [16];

  int checks = 0;
  int failures = 0;

  exp5_exibe_sequencia #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .limite    (limite),
    .dado_mem  (dado_mem),
    .endereco  (endereco),
    .leds      (leds),
    .exibindo  (exibindo),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  assign dado_mem = mem[endereco];

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
  endtask

  task automatic check_idle(input string name, input int step);
    checks += 5;
    if (leds !== 4'b0000) begin
      failures++; $display("FAIL %s step %0d leds=%b expected 0000", name, step, leds);
    end
    if (endereco !== 4'b0000) begin
      failures++; $display("FAIL %s step %0d endereco=%0d expected 0", name, step, endereco);
    end
    if (db_estado !== 4'b0000) begin
      failures++; $display("FAIL %s step %0d db_estado=%b expected 0000", name, step, db_estado);
    end
    if (exibindo !== 1'b0) begin
      failures++; $display("FAIL %s step %0d exibindo=%b expected 0", name, step, exibindo);
    end
    if (pronto !== 1'b0) begin
      failures++; $display("FAIL %s step %0d pronto=%b expected 0", name, step, pronto);
    end
  endtask

  // Starts a presentation with limit lim and follows it cycle by cycle.
  // perturb: pulse iniciar and change limite during the first lit window.
  // abort: assert reset during the second lit window and check the return to idle.
  task automatic run_show(input int lim, input bit perturb, input bit abort, input string name);
    int         st_q[$];
    logic [3:0] led_q[$];
    int         adr_q[$];
    int         n_acende;
    st_q.push_back(1); led_q.push_back(4'b0000); adr_q.push_back(0);
    for (int i = 0; i <= lim; i++) begin
      st_q.push_back(2); led_q.push_back(4'b0000); adr_q.push_back(i);
      for (int c = 0; c < ON; c++) begin
        st_q.push_back(3); led_q.push_back(mem[i]); adr_q.push_back(i);
      end
      for (int c = 0; c < OFF; c++) begin
        st_q.push_back(4); led_q.push_back(4'b0000); adr_q.push_back(i);
      end
      if (i < lim) begin
        st_q.push_back(5); led_q.push_back(4'b0000); adr_q.push_back(i);
      end
    end
    n_acende = 0;
    iniciar = 1'b1;
    limite = 4'(lim);
    for (int k = 0; k < st_q.size(); k++) begin
      @(posedge clock); #1;
      iniciar = 1'b0;
      checks += 5;
      if (db_estado !== 4'(st_q[k])) begin
        failures++; $display("FAIL %s step %0d db_estado=%b expected %b", name, k, db_estado, 4'(st_q[k]));
      end
      if (leds !== led_q[k]) begin
        failures++; $display("FAIL %s step %0d leds=%b expected %b", name, k, leds, led_q[k]);
      end
      if (endereco !== 4'(adr_q[k])) begin
        failures++; $display("FAIL %s step %0d endereco=%0d expected %0d", name, k, endereco, adr_q[k]);
      end
      if (exibindo !== 1'b1) begin
        failures++; $display("FAIL %s step %0d exibindo=%b expected 1", name, k, exibindo);
      end
      if (pronto !== 1'b0) begin
        failures++; $display("FAIL %s step %0d pronto=%b expected 0", name, k, pronto);
      end
      if (st_q[k] == 3 && (k == 0 || st_q[k-1] != 3)) n_acende++;
      if (perturb && n_acende == 1 && st_q[k] == 3) begin
        iniciar = 1'b1;
        limite = 4'($urandom);
      end
      if (abort && n_acende == 2) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_idle({name, "_after_reset"}, k + 1);
        return;
      end
    end
    @(posedge clock); #1;
    checks += 5;
    if (db_estado !== 4'b1000) begin
      failures++; $display("FAIL %s fim db_estado=%b expected 1000", name, db_estado);
    end
    if (pronto !== 1'b1) begin
      failures++; $display("FAIL %s fim pronto=%b expected 1", name, pronto);
    end
    if (exibindo !== 1'b0) begin
      failures++; $display("FAIL %s fim exibindo=%b expected 0", name, exibindo);
    end
    if (leds !== 4'b0000) begin
      failures++; $display("FAIL %s fim leds=%b expected 0000", name, leds);
    end
    if (endereco !== 4'(lim)) begin
      failures++; $display("FAIL %s fim endereco=%0d expected %0d", name, endereco, lim);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    iniciar = 1'b1;
    limite = 4'($urandom);
    @(posedge clock); #1;
    iniciar = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check_idle("reset", 0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      limite = 4'($urandom);
      @(posedge clock); #1;
      check_idle("idle", i);
    end
  endtask

  task automatic test_basic();
    fill_random();
    mem[0] = 4'b0001;
    mem[1] = 4'b0010;
    mem[2] = 4'b0100;
    run_show(2, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_limit0();
    fill_random();
    run_show(0, 1'b0, 1'b0, "limit0");
  endtask

  task automatic test_limit15();
    fill_random();
    run_show(15, 1'b0, 1'b0, "limit15");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_show(int'($urandom_range(1, 14)), 1'b0, 1'b0, "random");
    end
  endtask

  task automatic test_ignore_midrun();
    fill_random();
    run_show(int'($urandom_range(1, 6)), 1'b1, 1'b0, "ignore_midrun");
  endtask

  task automatic test_reset_mid();
    fill_random();
    run_show(3, 1'b0, 1'b1, "reset_mid");
    fill_random();
    run_show(int'($urandom_range(1, 5)), 1'b0, 1'b0, "restart");
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_show(1, 1'b0, 1'b0, "b2b_first");
    fill_random();
    run_show(4, 1'b0, 1'b0, "b2b_second");
  endtask

  initial begin
    reset = 1'b0;
    iniciar = 1'b0;
    limite = 4'b0000;
    for (int i = 0; i < 16; i++) mem[i] = 4'b0000;
    #2;
    test_reset();
    test_idle();
    test_basic();
    test_limit0();
    test_limit15();
    test_random();
    test_ignore_midrun();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
